// File: rtl/hit_reader_pkg.sv
// Shared types and constants for the hit-event reader: FSM states, synchroniser depth,
// post-clear holdoff length and the lane-index width helper.
package hit_reader_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESENT,
        CLEAR,
        HOLDOFF
    } state_e;

    localparam int SYNC_STAGES = 2;
    localparam int HOLDOFF_CYC = 3;

    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/rr_lane_pick.sv
// Combinational round-robin picker: first set flag at or after ptr_i, wrapping modulo LANES.
module rr_lane_pick
    import hit_reader_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0]              flags_i,
    input  logic [lane_w(LANES)-1:0]      ptr_i,
    output logic                          any_o,
    output logic [lane_w(LANES)-1:0]      lane_o
);

    localparam int LW = lane_w(LANES);

    // Walk offsets from farthest to nearest so the lane closest to the pointer wins.
    always_comb begin
        int idx;
        any_o  = 1'b0;
        lane_o = '0;
        idx    = 0;
        for (int i = LANES - 1; i >= 0; i--) begin
            idx = int'(ptr_i) + i;
            if (idx >= LANES) begin
                idx = idx - LANES;
            end
            if (flags_i[idx]) begin
                any_o  = 1'b1;
                lane_o = LW'(idx);
            end
        end
    end

endmodule

// File: rtl/hit_event_reader.sv
// Reads the SR-latch lane bank: synchronises flags, serves pending lanes round-robin over
// valid/ready, then pulses the served lane's clear. Define HIT_TIMESTAMP_EN to add ev_ts.
module hit_event_reader
    import hit_reader_pkg::*;
#(
    parameter int LANES = 4,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         flags_i,
    output logic [LANES-1:0]         clr_o,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [lane_w(LANES)-1:0] ev_lane
`ifdef HIT_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]          ev_ts
`endif
);

    localparam int LW     = lane_w(LANES);
    localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);

    // Handshake: an event transfers on a rising clk edge where ev_valid && ev_ready;
    // ev_valid and ev_lane (and ev_ts) stay stable until that edge.

    state_e             state_q;
    logic [LANES-1:0]   sync_q [SYNC_STAGES];
    logic [LANES-1:0]   flags_s;
    logic [LW-1:0]      ptr_q;
    logic [LW-1:0]      ptr_d;
    logic [LW-1:0]      ev_lane_q;
    logic               ev_valid_q;
    logic [LANES-1:0]   clr_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               pick_any;
    logic [LW-1:0]      pick_lane;

    assign flags_s = sync_q[SYNC_STAGES-1];
    assign ptr_d   = (ev_lane_q == LW'(LANES - 1)) ? '0 : ev_lane_q + LW'(1);

    rr_lane_pick #(
        .LANES(LANES)
    ) u_pick (
        .flags_i (flags_s),
        .ptr_i   (ptr_q),
        .any_o   (pick_any),
        .lane_o  (pick_lane)
    );

`ifdef HIT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] ts_d;
    logic [TS_W-1:0] ev_ts_q;

    assign ts_d  = ts_q + TS_W'(1);
    assign ev_ts = ev_ts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q    <= '0;
            ev_ts_q <= '0;
        end else begin
            ts_q <= ts_d;
            if (state_q == SCAN && pick_any) begin
                ev_ts_q <= ts_d;
            end
        end
    end
`else
    // TS_W only sizes the timestamp path; this empty block just marks it as consumed.
    if (TS_W < 1) begin : g_ts_w_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            state_q    <= SCAN;
            ptr_q      <= '0;
            ev_lane_q  <= '0;
            ev_valid_q <= 1'b0;
            clr_q      <= '0;
            hold_q     <= '0;
        end else begin
            sync_q[0] <= flags_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            case (state_q)
                SCAN: begin
                    if (pick_any) begin
                        ev_lane_q  <= pick_lane;
                        ev_valid_q <= 1'b1;
                        state_q    <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ev_ready) begin
                        ev_valid_q <= 1'b0;
                        clr_q      <= LANES'(1) << ev_lane_q;
                        ptr_q      <= ptr_d;
                        state_q    <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_q   <= '0;
                    hold_q  <= HOLD_W'(HOLDOFF_CYC);
                    state_q <= HOLDOFF;
                end
                HOLDOFF: begin
                    // Lets the cleared lane's stale synchronised flag drain before rescanning.
                    if (hold_q == '0) begin
                        state_q <= SCAN;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign clr_o    = clr_q;
    assign ev_valid = ev_valid_q;
    assign ev_lane  = ev_lane_q;

endmodule

// File: doc/hit_event_reader.md
Name: hit_event_reader

Overview:
- Read-side companion to the 4-bit SR-latch lane register. The latches capture asynchronous key-hit events (S side).
- This block synchronises the latched lane flags, selects pending lanes round-robin, and presents each one as an event to game logic over a valid/ready handshake.
- After each handshake it pulses that lane's latch reset (R side) to consume the event.
- Sits between the Register4bit latch bank and the score/judgement logic.

Parameters:
- LANES, 4, number of latched lanes (≥2).
- TS_W, 16, timestamp width (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flags_i  in  LANES  Q outputs of the lane latches; asynchronous to clk.
- clr_o  out  LANES  one-hot, one-cycle clear pulse to the latch R inputs.
- ev_valid  out  1  event present.
- ev_ready  in  1  consumer accepts the event.
- ev_lane  out  $clog2(LANES)  lane index of the presented event.
- ev_ts  out  TS_W  capture timestamp (present only with HIT_TIMESTAMP_EN).

Behaviour:
- Clocking and reset: one clock; reset is synchronous, active-high, on rst.
- Reset values:
  - clr_o=0, ev_valid=0, ev_lane=0, ev_ts=0.
  - Synchroniser flops=0, round-robin pointer=0, state=SCAN, holdoff counter=0.
- Synchroniser: each flags_i bit passes through 2 flops to give flags_s. Only flags_s is used internally.
- SCAN state:
  - If flags_s is non-zero, pick the first set lane at or after the pointer, wrapping modulo LANES.
  - Register the pick into ev_lane, set ev_valid=1 on the next edge, and go to PRESENT.
  - If flags_s is zero, stay in SCAN.
- PRESENT state:
  - ev_valid and ev_lane are held stable until ev_valid&&ev_ready.
  - ev_ready while ev_valid=0 is ignored.
  - On handshake, the next edge drives ev_valid=0, clr_o[ev_lane]=1 and pointer=(ev_lane+1) mod LANES, and goes to CLEAR.
- CLEAR state:
  - clr_o is high for exactly this one cycle.
  - Next edge: clr_o=0, holdoff counter=3, go to HOLDOFF.
- HOLDOFF state:
  - Counts down 3 cycles to cover the 2-stage synchroniser lag, so a stale flags_s of the cleared lane is never re-presented.
  - When the counter reaches 0, return to SCAN. Other lanes stay latched meanwhile; nothing is lost.
- Latency:
  - flags_i rising to ev_valid high is 3 clk edges when idle (2 sync + 1 select).
  - Handshake to the next possible ev_valid is 6 edges.
- Boundary conditions:
  - All lanes pending: served in pointer order, e.g. 0,1,2,3,0… Each lane is served at most once per LANES events, so there is no starvation.
  - A lane re-hit during its own CLEAR cycle: the latch sees S and R together and the result is latch-defined. That hit may be lost; accepted limitation.
  - A re-hit after CLEAR is captured and served normally.
  - ev_ready held high permanently: events still go out one per 6 cycles minimum.
  - rst mid-PRESENT or mid-CLEAR: everything returns to reset values on that edge. No clr_o pulse is issued, so pending latches remain set and are re-presented after reset.

Optional Feature:
- Macro: HIT_TIMESTAMP_EN.
- Defined:
  - A free-running TS_W counter is cleared by rst and wraps at 2^TS_W.
  - Its value is captured into ev_ts on the SCAN→PRESENT edge and held with ev_lane.
- Undefined: no counter, and no ev_ts port.

Decomposition:
- Package hit_reader_pkg holds:
  - state enum {SCAN, PRESENT, CLEAR, HOLDOFF};
  - SYNC_STAGES=2;
  - HOLDOFF_CYC=3;
  - the LANE_W function/constant.
- One natural sub-module: rr_lane_pick, a combinational round-robin first-set picker.
  - Inputs: flags, pointer.
  - Outputs: any, lane index.

Test Plan:
- Reset, then flags_i=4'b0100 held with ev_ready=1 → ev_valid high 3 edges later with ev_lane=2. clr_o=4'b0100 for exactly 1 cycle after the handshake. Release the latch → ev_valid stays 0.
- flags_i=4'b1111, ev_ready=1, each lane dropping 2 cycles after its clr_o → events in order lane 0,1,2,3. Exactly 4 clr_o pulses, each one-hot.
- Pointer at 3 after a lane-2 event, then flags 4'b0101 → next ev_lane=0 (wrap), then 2.
- ev_valid high with ev_ready=0 for 20 cycles, and flags_i changing to 4'b1011 → ev_lane unchanged, clr_o stays 0 throughout.
- rst asserted during PRESENT with flags 4'b0010 → next cycle all outputs 0, no clr_o. After rst release, lane 1 is presented again at +3 edges.
- With HIT_TIMESTAMP_EN: assert lane 3 at counter=100 → ev_ts=103. Assert near 2^16-1 → ev_ts wraps to a small value.
